// File: rtl/rr_bus_scheduler_pkg.sv
// Shared types and helpers for the round-robin bus scheduler and related arbiters.
// Provides the scheduler state encoding and the modulo-N pointer advance.
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Advance a rotation pointer, wrapping at n-1 rather than at a power of two.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_bus_scheduler_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request at or
// after rr_ptr, wrapping at N_REQ-1.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] request,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_valid
);

    localparam int PW = IDX_W + 1;

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [PW-1:0]      w_off;
    logic [PW-1:0]      w_sum;

    // Doubling the vector turns the wrap-around scan into a plain shift.
    assign w_dbl = {request, request};
    assign w_rot = N_REQ'(w_dbl >> rr_ptr);

    always_comb begin
        w_off      = '0;
        pick_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off      = PW'(k);
                pick_valid = 1'b1;
            end
        end
        w_sum = {1'b0, rr_ptr} + w_off;
        if (w_sum >= PW'(N_REQ)) begin
            w_sum = w_sum - PW'(N_REQ);
        end
    end

    assign pick_idx = w_sum[IDX_W-1:0];

endmodule

// File: rtl/rr_bus_scheduler.sv
// Round-robin owner of a shared bus: grants whole transfers, bounds hold time,
// and inserts a one-cycle turnaround gap between owners.
//
//   state | meaning
//   IDLE  | bus unowned, waiting for any request
//   GRANT | grant_idx owns the bus; exits on done, request drop or hold limit
//   GAP   | single turnaround cycle with no grant, then re-arbitrate
module rr_bus_scheduler #(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    import bus_sched_pkg::*;

    localparam int                HC_W      = $clog2(MAX_HOLD);
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(MAX_HOLD - 1);
    localparam logic [N_REQ-1:0]  ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e           r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [HC_W-1:0]  r_hold_cnt;
    logic [N_REQ-1:0] r_grant;
    logic             r_grant_valid;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_timeout;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_owner_done;
    logic             w_owner_req;
    logic             w_hold_last;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .request    (request),
        .rr_ptr     (r_rr_ptr),
        .pick_idx   (w_pick_idx),
        .pick_valid (w_pick_valid)
    );

    // Masking with the one-hot grant ignores done/request from non-owners.
    assign w_owner_done = |(done & r_grant);
    assign w_owner_req  = |(request & r_grant);
    assign w_hold_last  = (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE, GAP: begin
                    if (w_pick_valid) begin
                        r_state       <= GRANT;
                        r_grant       <= ONE_HOT0 << w_pick_idx;
                        r_grant_valid <= 1'b1;
                        r_grant_idx   <= w_pick_idx;
                        r_hold_cnt    <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GRANT: begin
                    if (w_owner_done || !w_owner_req || w_hold_last) begin
                        // A done on the last allowed cycle is a normal end, not a revoke.
                        r_timeout     <= !w_owner_done && w_owner_req;
                        r_state       <= GAP;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_grant_idx   <= '0;
                        r_rr_ptr      <= IDX_W'(rr_next(int'(r_grant_idx), N_REQ));
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                    r_grant_idx   <= '0;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Directed bench for rr_bus_scheduler: a 4-requester instance (MAX_HOLD=16)
// and a 3-requester instance (MAX_HOLD=4) share clock and reset.
module tb_rr_bus_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request, done, grant;
    logic       grant_valid, timeout;
    logic [1:0] grant_idx;
    logic [2:0] req3, done3, grant3;
    logic       grant_valid3, timeout3;
    logic [1:0] grant_idx3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rr_bus_scheduler #(.N_REQ(4), .MAX_HOLD(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    rr_bus_scheduler #(.N_REQ(3), .MAX_HOLD(4)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .request     (req3),
        .done        (done3),
        .grant       (grant3),
        .grant_valid (grant_valid3),
        .grant_idx   (grant_idx3),
        .timeout     (timeout3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [3:0] seq [5];

    initial begin
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1; request = '0; done = '0; req3 = '0; done3 = '0;
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_gv", 32'(grant_valid), 32'h0);
        check("rst_idx", 32'(grant_idx), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_grant3", 32'(grant3), 32'h0);

        // single requester, done after 3 grant cycles
        reset = 1'b0; request = 4'b0001;
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_gv", 32'(grant_valid), 32'h1);
        check("t1_idx", 32'(grant_idx), 32'h0);
        tick();
        check("t1_hold2", 32'(grant), 32'h1);
        tick();
        check("t1_hold3", 32'(grant), 32'h1);
        done = 4'b0001;
        tick();
        check("t1_gap", 32'(grant), 32'h0);
        check("t1_gap_gv", 32'(grant_valid), 32'h0);
        check("t1_gap_to", 32'(timeout), 32'h0);
        done = '0; request = '0;
        tick();
        check("t1_idle", 32'(grant), 32'h0);
        request = 4'b0011;
        tick();
        check("t1_rrptr", 32'(grant), 32'h2);
        check("t1_rrptr_idx", 32'(grant_idx), 32'h1);
        done = 4'b0010;
        tick();
        request = '0; done = '0;
        tick();
        check("t1_idle2", 32'(grant), 32'h0);

        // full rotation with all requesting
        reset = 1'b1;
        tick();
        reset = 1'b0; request = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_grant_a", 32'(grant), 32'(seq[i]));
            tick();
            check("t2_grant_b", 32'(grant), 32'(seq[i]));
            done = seq[i];
            tick();
            check("t2_gap", 32'(grant), 32'h0);
            check("t2_gap_gv", 32'(grant_valid), 32'h0);
            done = '0;
        end
        request = '0;
        tick();
        check("t2_idle", 32'(grant), 32'h0);

        // hold limit revoke
        reset = 1'b1;
        tick();
        reset = 1'b0; request = 4'b0011;
        tick();
        for (int c = 0; c < 16; c++) begin
            check("t3_hold", 32'(grant), 32'h1);
            check("t3_no_to", 32'(timeout), 32'h0);
            tick();
        end
        check("t3_revoked", 32'(grant), 32'h0);
        check("t3_timeout", 32'(timeout), 32'h1);
        tick();
        check("t3_next", 32'(grant), 32'h2);
        check("t3_to_clear", 32'(timeout), 32'h0);
        done = 4'b0010;
        tick();
        done = '0; request = '0;
        tick();

        // N_REQ=3 wrap, hold limit, done on last cycle
        req3 = 3'b100;
        tick();
        check("t4_grant", 32'(grant3), 32'h4);
        check("t4_idx", 32'(grant_idx3), 32'h2);
        done3 = 3'b100;
        tick();
        check("t4_gap", 32'(grant3), 32'h0);
        done3 = '0; req3 = '0;
        tick();
        req3 = 3'b101;
        tick();
        check("t4_wrap", 32'(grant3), 32'h1);
        check("t4_wrap_idx", 32'(grant_idx3), 32'h0);
        done3 = 3'b001;
        tick();
        done3 = '0; req3 = 3'b010;
        tick();
        check("t4b_grant", 32'(grant3), 32'h2);
        tick();
        tick();
        tick();
        check("t4b_last", 32'(grant3), 32'h2);
        tick();
        check("t4b_revoked", 32'(grant3), 32'h0);
        check("t4b_timeout", 32'(timeout3), 32'h1);
        tick();
        check("t4c_regrant", 32'(grant3), 32'h2);
        check("t4c_to_clear", 32'(timeout3), 32'h0);
        tick();
        tick();
        tick();
        done3 = 3'b010;
        tick();
        check("t4c_end", 32'(grant3), 32'h0);
        check("t4c_done_no_to", 32'(timeout3), 32'h0);
        done3 = '0; req3 = '0;
        tick();

        // non-owner activity ignored, then abandon
        reset = 1'b1;
        tick();
        reset = 1'b0; request = 4'b0010;
        tick();
        check("t5_grant", 32'(grant), 32'h2);
        check("t5_idx", 32'(grant_idx), 32'h1);
        done = 4'b0100; request = 4'b1010;
        tick();
        check("t5_ignore_a", 32'(grant), 32'h2);
        done = '0; request = 4'b0010;
        tick();
        check("t5_ignore_b", 32'(grant), 32'h2);
        request = 4'b1010;
        tick();
        check("t5_ignore_c", 32'(grant), 32'h2);
        request = 4'b1000;
        tick();
        check("t5_abandon", 32'(grant), 32'h0);
        check("t5_abandon_to", 32'(timeout), 32'h0);
        request = 4'b0111;
        tick();
        check("t5_rrptr", 32'(grant), 32'h4);
        done = 4'b0100;
        tick();
        done = '0; request = 4'b1000;
        tick();
        check("t6_grant", 32'(grant), 32'h8);
        for (int c = 0; c < 5; c++) tick();
        check("t6_still", 32'(grant), 32'h8);

        // reset mid-grant
        reset = 1'b1;
        tick();
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_gv", 32'(grant_valid), 32'h0);
        check("t6_rst_idx", 32'(grant_idx), 32'h0);
        check("t6_rst_to", 32'(timeout), 32'h0);
        reset = 1'b0;
        tick();
        check("t6_regrant", 32'(grant), 32'h8);
        check("t6_regrant_idx", 32'(grant_idx), 32'h3);
        done = 4'b1000; request = '0;
        tick();
        done = '0;
        tick();
        check("t6_idle", 32'(grant), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
